// File: rtl/colpar_pkg.sv
`default_nettype none
//==============================================================================
// Module   : colpar_pkg
// Brief    : Shared types, default geometry and width helpers for the
//            column-parity generator.
// Revision : 1.0 - initial release
//==============================================================================
package colpar_pkg;

   // Default frame geometry
   localparam int LANE_W_D = 64;   // z positions per x-row
   localparam int ROWS_D   = 5;    // bits per column (y extent)
   localparam int COLS_D   = 5;    // x-rows per frame

   // Frame-level control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width for an extent: $clog2, never narrower than one bit
   function automatic int cnt_w(input int extent);
      return (extent > 1) ? $clog2(extent) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/colpar_if.sv
`default_nettype none
//==============================================================================
// Module   : colpar_if
// Brief    : Stream-in / parity-out bundle of the column-parity generator.
// Revision : 1.0 - initial release
//==============================================================================
interface colpar_if;

   logic start;      // frame start pulse
   logic abort;      // synchronous frame cancel
   logic din;        // serial state bit
   logic din_valid;  // din qualifier
   logic pout;       // column parity bit
   logic pout_en;    // parity strobe
   logic co;         // last column of the x-row
   logic busy;       // frame in progress
   logic done;       // frame complete pulse

   // Stream source / parity sink side
   modport master (
      output start, abort, din, din_valid,
      input  pout, pout_en, co, busy, done
   );

   // Generator side
   modport slave (
      input  start, abort, din, din_valid,
      output pout, pout_en, co, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/colpar_idx_cnt.sv
`default_nettype none
//==============================================================================
// Module   : colpar_idx_cnt
// Brief    : Nested y/z/x position counter. y runs fastest (bits within a
//            column), then z (column within an x-row), then x (row of frame).
// Revision : 1.0 - initial release
//==============================================================================
module colpar_idx_cnt
   import colpar_pkg::*;
#(
   parameter int LANE_W = LANE_W_D,
   parameter int ROWS   = ROWS_D,
   parameter int COLS   = COLS_D
) (
   input  wire  clk,
   input  wire  rst,           // asynchronous, active-low
   input  wire  clr_i,         // synchronous clear, wins over en_i
   input  wire  en_i,          // advance by one accepted bit
   output logic col_last_o,    // y at ROWS-1
   output logic row_last_o,    // col_last and z at LANE_W-1
   output logic frame_last_o   // row_last and x at COLS-1
);

   localparam int YW = cnt_w(ROWS);
   localparam int ZW = cnt_w(LANE_W);
   localparam int XW = cnt_w(COLS);

   logic [YW-1:0] y_q, y_d;
   logic [ZW-1:0] z_q, z_d;
   logic [XW-1:0] x_q, x_d;
   logic          y_last, z_last, x_last;

   // Explicit terminal compares so non-power-of-two extents wrap correctly
   assign y_last = (y_q == YW'(ROWS - 1));
   assign z_last = (z_q == ZW'(LANE_W - 1));
   assign x_last = (x_q == XW'(COLS - 1));

   assign col_last_o   = y_last;
   assign row_last_o   = y_last & z_last;
   assign frame_last_o = y_last & z_last & x_last;

   // Next position: y carries into z, z carries into x, x wraps at frame end
   always_comb begin
      y_d = y_q;
      z_d = z_q;
      x_d = x_q;
      if (clr_i) begin
         y_d = '0;
         z_d = '0;
         x_d = '0;
      end else if (en_i) begin
         if (!y_last) begin
            y_d = y_q + 1'b1;
         end else begin
            y_d = '0;
            if (!z_last) begin
               z_d = z_q + 1'b1;
            end else begin
               z_d = '0;
               x_d = x_last ? '0 : x_q + 1'b1;
            end
         end
      end
   end

   // Position registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_q <= '0;
         z_q <= '0;
         x_q <= '0;
      end else begin
         y_q <= y_d;
         z_q <= z_d;
         x_q <= x_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/colpar_gen.sv
`default_nettype none
//==============================================================================
// Module   : colpar_gen
// Brief    : Column-parity generator. Folds a column-ordered serial stream
//            into one XOR parity bit per column, flagging the last column of
//            each x-row on co for the downstream line writer.
// Revision : 1.0 - initial release
//==============================================================================
module colpar_gen
   import colpar_pkg::*;
#(
   parameter int LANE_W = LANE_W_D,
   parameter int ROWS   = ROWS_D,
   parameter int COLS   = COLS_D
) (
   input  wire     clk,
   input  wire     rst,        // asynchronous, active-low
   colpar_if.slave bus
);

   state_e state_q;
   logic   acc_q;
   logic   pout_q, pout_en_q, co_q, busy_q, done_q;

   logic   accept;
   logic   cnt_clr;
   logic   col_last, row_last, frame_last;

   // A bit is consumed only while running and not being cancelled
   assign accept  = (state_q == RUN) & bus.din_valid & ~bus.abort;
   // Positions restart on every frame start and on every cancel
   assign cnt_clr = bus.abort | ((state_q == IDLE) & bus.start);

   colpar_idx_cnt #(
      .LANE_W (LANE_W),
      .ROWS   (ROWS),
      .COLS   (COLS)
   ) u_idx (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (cnt_clr),
      .en_i         (accept),
      .col_last_o   (col_last),
      .row_last_o   (row_last),
      .frame_last_o (frame_last)
   );

   // Frame FSM, parity accumulator and registered outputs; the strobes
   // default low each cycle so pout/co are zero whenever pout_en is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         acc_q     <= 1'b0;
         pout_q    <= 1'b0;
         pout_en_q <= 1'b0;
         co_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         pout_q    <= 1'b0;
         pout_en_q <= 1'b0;
         co_q      <= 1'b0;
         done_q    <= 1'b0;
         if (bus.abort) begin
            // Cancel beats both start and din_valid
            state_q <= IDLE;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     state_q <= RUN;
                     acc_q   <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.din_valid) begin
                     if (col_last) begin
                        pout_q    <= acc_q ^ bus.din;
                        pout_en_q <= 1'b1;
                        co_q      <= row_last;
                        acc_q     <= 1'b0;
                        if (frame_last) begin
                           state_q <= DONE;
                           done_q  <= 1'b1;
                           busy_q  <= 1'b0;
                        end
                     end else begin
                        acc_q <= acc_q ^ bus.din;
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.pout    = pout_q;
   assign bus.pout_en = pout_en_q;
   assign bus.co      = co_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_colpar_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_colpar_gen
// Brief    : Directed self-checking bench for colpar_gen: a small 4x5x2
//            instance for frame/stall/abort/reset cases and a default
//            64x5x5 instance for the z-parity pattern frame.
// Revision : 1.0 - initial release
//==============================================================================
module tb_colpar_gen;
   import colpar_pkg::*;

   localparam int S_LANE = 4;
   localparam int S_ROWS = 5;
   localparam int S_COLS = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   colpar_if ifs ();
   colpar_if ifd ();

   colpar_gen #(.LANE_W(S_LANE), .ROWS(S_ROWS), .COLS(S_COLS)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (ifs)
   );

   colpar_gen u_dflt (
      .clk (clk),
      .rst (rst),
      .bus (ifd)
   );

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // ---------------- small instance monitor ----------------
   logic [4:0] s_cols [8];
   logic [7:0] s_pv, s_cv, s_dv;
   int         s_n, s_zero_viol, s_done_cnt, s_busy_low;

   always @(negedge clk) begin
      if (ifs.pout_en) begin
         if (s_n < 8) begin
            s_pv[s_n] = ifs.pout;
            s_cv[s_n] = ifs.co;
            s_dv[s_n] = ifs.done;
         end
         s_n++;
      end else if (ifs.pout | ifs.co) begin
         s_zero_viol++;
      end
      if (ifs.done) s_done_cnt++;
   end

   task automatic s_clear();
      s_n = 0; s_pv = '0; s_cv = '0; s_dv = '0;
      s_zero_viol = 0; s_done_cnt = 0; s_busy_low = 0;
   endtask

   task automatic s_start();
      ifs.start = 1'b1;
      @(posedge clk); #1;
      ifs.start = 1'b0;
   endtask

   // Feed bits [first, first+count); mode 0 = all ones, 1 = s_cols table
   task automatic s_bits(input int first, input int count, input int mode, input int max_gap);
      for (int i = first; i < first + count; i++) begin
         if (max_gap > 0) begin
            repeat ($urandom_range(max_gap, 0)) begin
               if (ifs.busy !== 1'b1) s_busy_low++;
               ifs.din_valid = 1'b0;
               ifs.din       = ~ifs.din;
               @(posedge clk); #1;
            end
         end
         if (ifs.busy !== 1'b1) s_busy_low++;
         ifs.din_valid = 1'b1;
         ifs.din       = (mode == 0) ? 1'b1 : s_cols[i / 5][i % 5];
         @(posedge clk); #1;
      end
      ifs.din_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- default instance monitor ----------------
   logic d_col_end = 1'b0;
   logic d_exp_en  = 1'b0;
   int   d_n = 0, d_pout_err = 0, d_co_cnt = 0, d_co_err = 0;
   int   d_lat_err = 0, d_done_cnt = 0, d_done_err = 0;

   // Strobe expected one cycle after a column's final valid bit
   always @(posedge clk) d_exp_en <= ifd.din_valid & d_col_end;

   always @(negedge clk) begin
      if (ifd.pout_en !== d_exp_en) d_lat_err++;
      if (ifd.pout_en) begin
         if (ifd.pout !== 1'(d_n % 2)) d_pout_err++;
         if (ifd.co !== ((d_n % LANE_W_D) == LANE_W_D - 1)) d_co_err++;
         if (ifd.done !== (d_n == LANE_W_D * COLS_D - 1)) d_done_err++;
         if (ifd.co) d_co_cnt++;
         d_n++;
      end else if (ifd.done) begin
         d_done_err++;
      end
      if (ifd.done) d_done_cnt++;
   end

   task automatic dflt_frame(input int max_gap);
      ifd.start = 1'b1;
      @(posedge clk); #1;
      ifd.start = 1'b0;
      for (int x = 0; x < COLS_D; x++) begin
         for (int z = 0; z < LANE_W_D; z++) begin
            for (int y = 0; y < ROWS_D; y++) begin
               if (max_gap > 0) begin
                  repeat ($urandom_range(max_gap, 0)) begin
                     ifd.din_valid = 1'b0;
                     ifd.din       = 1'b1;
                     d_col_end     = 1'b0;
                     @(posedge clk); #1;
                  end
               end
               ifd.din_valid = 1'b1;
               ifd.din       = (y == 0) ? 1'(z % 2) : 1'b0;
               d_col_end     = (y == ROWS_D - 1);
               @(posedge clk); #1;
            end
         end
      end
      ifd.din_valid = 1'b0;
      d_col_end     = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Column words, bit y at position y; parities 1,0,1,1,0,0,1,1
      s_cols[0] = 5'b00001; s_cols[1] = 5'b00011;
      s_cols[2] = 5'b10101; s_cols[3] = 5'b11111;
      s_cols[4] = 5'b00000; s_cols[5] = 5'b01100;
      s_cols[6] = 5'b10000; s_cols[7] = 5'b01110;

      ifs.start = 0; ifs.abort = 0; ifs.din = 0; ifs.din_valid = 0;
      ifd.start = 0; ifd.abort = 0; ifd.din = 0; ifd.din_valid = 0;
      s_clear();
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset held with live input traffic
      ifs.din_valid = 1'b1; ifd.din_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         ifs.din = ~ifs.din; ifd.din = ~ifd.din;
      end
      chk("rst_outs_small", {ifs.pout, ifs.pout_en, ifs.co, ifs.busy, ifs.done}, 0);
      chk("rst_outs_dflt",  {ifd.pout, ifd.pout_en, ifd.co, ifd.busy, ifd.done}, 0);
      rst = 1'b1;

      // Released but never started: din_valid ignored
      repeat (6) begin
         @(posedge clk); #1;
         ifs.din = ~ifs.din; ifd.din = ~ifd.din;
      end
      ifs.din_valid = 1'b0; ifd.din_valid = 1'b0;
      chk("idle_no_pout_small", s_n, 0);
      chk("idle_no_pout_dflt", d_n, 0);
      chk("idle_busy", {ifs.busy, ifd.busy}, 0);

      // All-ones small frame, no stalls
      s_clear(); s_start(); s_bits(0, 40, 0, 0);
      idle(1);
      chk("ones_busy_after_done", ifs.busy, 0);
      idle(2);
      chk("ones_pulses", s_n, 8);
      chk("ones_pout", s_pv, 8'hFF);
      chk("ones_co", s_cv, 8'h88);
      chk("ones_done_pos", s_dv, 8'h80);
      chk("ones_done_cnt", s_done_cnt, 1);
      chk("ones_zero_idle", s_zero_viol, 0);

      // Table pattern, no stalls
      s_clear(); s_start(); s_bits(0, 40, 1, 0); idle(3);
      chk("pat_pulses", s_n, 8);
      chk("pat_pout", s_pv, 8'b11001101);
      chk("pat_co", s_cv, 8'h88);
      chk("pat_done_cnt", s_done_cnt, 1);

      // Same table with stalls of 0..3 cycles
      s_clear(); s_start(); s_bits(0, 40, 1, 3); idle(3);
      chk("stall_pulses", s_n, 8);
      chk("stall_pout", s_pv, 8'b11001101);
      chk("stall_co", s_cv, 8'h88);
      chk("stall_done_pos", s_dv, 8'h80);
      chk("stall_busy_low", s_busy_low, 0);
      chk("stall_zero_idle", s_zero_viol, 0);

      // Abort after 13 bits, with din_valid and start also high
      s_clear(); s_start(); s_bits(0, 13, 0, 0);
      ifs.abort = 1; ifs.din_valid = 1; ifs.din = 1; ifs.start = 1;
      @(posedge clk); #1;
      ifs.abort = 0; ifs.din_valid = 0; ifs.start = 0;
      idle(2);
      chk("abort13_pulses", s_n, 2);
      chk("abort13_busy", ifs.busy, 0);
      ifs.din_valid = 1; idle(6); ifs.din_valid = 0; idle(1);
      chk("abort13_idle_pulses", s_n, 2);
      chk("abort13_done", s_done_cnt, 0);

      // start and abort together in IDLE
      ifs.start = 1; ifs.abort = 1;
      @(posedge clk); #1;
      ifs.start = 0; ifs.abort = 0;
      idle(1);
      chk("start_abort_idle_busy", ifs.busy, 0);

      // Full frame after abort
      s_clear(); s_start(); s_bits(0, 40, 1, 0); idle(3);
      chk("post_abort_pulses", s_n, 8);
      chk("post_abort_pout", s_pv, 8'b11001101);
      chk("post_abort_co", s_cv, 8'h88);

      // Abort in the cycle a parity strobe is already on the output
      s_clear(); s_start(); s_bits(0, 15, 0, 0);
      ifs.abort = 1; ifs.din_valid = 1; ifs.din = 1;
      @(posedge clk); #1;
      ifs.abort = 0; ifs.din_valid = 0;
      idle(3);
      chk("abort15_trailing_pulses", s_n, 3);
      chk("abort15_done", s_done_cnt, 0);

      // Asynchronous reset between edges while pout_en is high
      s_clear(); s_start(); s_bits(0, 15, 0, 0);
      chk("pre_rst_pout_en", ifs.pout_en, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_outs", {ifs.pout, ifs.pout_en, ifs.co, ifs.busy, ifs.done}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      idle(1);
      s_clear(); s_start(); s_bits(0, 40, 1, 2); idle(3);
      chk("post_rst_pulses", s_n, 8);
      chk("post_rst_pout", s_pv, 8'b11001101);
      chk("post_rst_co", s_cv, 8'h88);
      chk("post_rst_done_pos", s_dv, 8'h80);

      // Default geometry, y==0 ? z[0] : 0 pattern, occasional stalls
      dflt_frame(1); idle(3);
      chk("dflt_pulses", d_n, LANE_W_D * COLS_D);
      chk("dflt_pout", d_pout_err, 0);
      chk("dflt_co_cnt", d_co_cnt, COLS_D);
      chk("dflt_co_pos", d_co_err, 0);
      chk("dflt_done_cnt", d_done_cnt, 1);
      chk("dflt_done_pos", d_done_err, 0);
      chk("dflt_latency", d_lat_err, 0);
      chk("dflt_busy_end", ifd.busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/colpar_gen.md
Name: colpar_gen

Overview:
- Upstream stage of the column-parity file writer.
- Consumes the encoder state as a serial bit stream, ordered column by column.
- Computes the XOR parity of each column over ROWS bits.
- Emits one parity bit per column on pout/pout_en, with co marking the last column of each x-row. The downstream writer breaks lines on co.

Parameters:
- LANE_W, 64, number of z positions per x-row; equals parity bits per output line.
- ROWS, 5, bits per column (y extent) XORed into one parity bit.
- COLS, 5, number of x-rows; equals output lines per frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- abort  input  1  synchronous frame cancel; returns the block to IDLE.
- din  input  1  serial state bit.
- din_valid  input  1  din is valid this cycle. Gaps (stalls) are allowed.
- pout  output  1  column parity bit; connects to the writer's pin.
- pout_en  output  1  pout valid strobe; connects to the writer's en.
- co  output  1  last column of the current x-row, qualified by pout_en; connects to the writer's co.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the frame's final parity bit.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; y/z/x counters=0; acc=0.
- Reset value of every output is 0: pout, pout_en, co, busy, done.
- Reset mid-frame discards the partial frame with no further pout_en.
- States:
  - IDLE: start -> RUN, counters cleared, acc=0. din_valid is ignored.
  - RUN: busy=1.
    - Each din_valid cycle: if y<ROWS-1, then acc<=acc^din and y++.
    - If y==ROWS-1: the next cycle drives pout=acc^din, pout_en=1, co=(z==LANE_W-1). Then acc<=0, y<=0, z++.
    - z wraps LANE_W-1 -> 0 with x++.
    - When the bit at x==COLS-1, z==LANE_W-1, y==ROWS-1 is accepted -> DONE.
  - DONE: done=1 for exactly one cycle (the same cycle as the final pout_en/co), then IDLE.
- Latency: the parity bit appears exactly 1 cycle after the column's last valid bit. pout_en is a single-cycle pulse per column.
- Output is registered, with no combinational path from din to pout.
- A din_valid=0 cycle freezes counters and acc. No bubbles are inserted other than input stalls.
- pout and co are held at 0 whenever pout_en=0.
- start while in RUN or DONE is ignored.
- abort has priority over din_valid in the same cycle.
  - Abort in RUN: counters and acc clear, -> IDLE, no done pulse.
  - A pout_en already scheduled from the previous cycle's accepted bit is still issued.
- start and abort asserted together in IDLE: abort wins and the block stays IDLE.
- Frame totals: COLS*LANE_W*ROWS input bits, COLS*LANE_W pout_en pulses, COLS co pulses.
- Counter widths: $clog2 of each extent, minimum 1 bit. Comparisons are against extent-1 and do not rely on natural wrap.

Decomposition:
- Package colpar_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - default constants LANE_W_D=64, ROWS_D=5, COLS_D=5;
  - width localparam functions.
- One sub-module: colpar_idx_cnt, a nested y/z/x counter with enable.
  - Outputs col_last (y==ROWS-1), row_last (col_last & z==LANE_W-1) and frame_last.
  - Synchronous clear; asynchronous active-low reset.
- Top level holds the FSM, the parity accumulator and the output registers.

Test Plan:
- Reset/idle: rst low with din_valid=1 and din=1 toggling -> all outputs 0. After rst release without start -> no pout_en.
- Small frame (LANE_W=4, ROWS=5, COLS=2), all-ones stream of 40 bits, no stalls:
  - 8 pout_en pulses, each with pout=1;
  - co on pulses 4 and 8;
  - done coincides with pulse 8;
  - busy low the cycle after done.
- Pattern check (default params): column (x,z) bits = y==0 ? z[0] : 0 -> pout sequence 0,1,0,1... per line; 5 co pulses; 320 pout_en total; each pout_en exactly 1 cycle after the column's 5th valid bit.
- Stalls: random din_valid gaps of 0–3 cycles on the LANE_W=4 frame -> identical pout/co sequence to the no-stall run; busy stays high throughout.
- Abort mid-frame: abort after 13 bits -> at most 1 trailing pout_en, then IDLE, no done. A following start plus full frame -> correct 8 parity bits.
- Async reset mid-frame: rst pulled low between clock edges -> outputs clear immediately. A subsequent start produces a full correct frame.
